// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register between RV32 stages.
// Valid/ready handshake, flush to bubble, optional two-entry skid buffer.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous kill of all held beats (highest priority)
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_ctrl    upstream control bundle (CTRL_W)
//   in_data    upstream payload (DATA_W)
//   out_valid  downstream beat present
//   out_ready  downstream accepts this cycle (0 = stall)
//   out_ctrl   control bundle, 0 whenever out_valid=0
//   out_data   payload, don't-care when out_valid=0
//   occupancy  number of held beats (0..2)
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam bit HAS_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic drain;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;
    logic clr_main;
    logic clr_skid;

    assign out_valid = (state != EMPTY);
    assign drain     = out_valid && out_ready;
    // A beat offered alongside flush is dropped.
    assign accept    = in_valid && in_ready && !flush;

    generate
        if (HAS_SKID) begin : g_skid
            // Depends on the state register only: no out_ready path.
            assign in_ready = (state != TWO);
        end else begin : g_pass
            assign in_ready = rst ? (!out_valid || out_ready) : out_ready;
        end
    endgenerate

    always_comb begin
        state_nx     = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        clr_main     = 1'b0;
        clr_skid     = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
            clr_main = 1'b1;
            clr_skid = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nx   = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        ld_main_in = 1'b1;
                    end else if (accept && HAS_SKID) begin
                        state_nx = TWO;
                        ld_skid  = 1'b1;
                    end else if (drain) begin
                        state_nx = EMPTY;
                        clr_main = 1'b1;
                    end
                end
                TWO: begin
                    // Skid beat is younger, so it moves up only after main drains.
                    if (drain) begin
                        state_nx     = ONE;
                        ld_main_skid = 1'b1;
                        clr_skid     = 1'b1;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    clr_main = 1'b1;
                    clr_skid = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (ld_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end else if (clr_main) begin
                main_ctrl <= '0;
            end
            if (ld_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end else if (clr_skid) begin
                skid_ctrl <= '0;
            end
        end
    end

    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg
// for SKID=1 and SKID=0 against a queue-based reference.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 12;

    typedef logic [CW+DW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          ir1, ov1, ir0, ov0;
    logic [CW-1:0] oc1, oc0;
    logic [DW-1:0] od1, od0;
    logic [1:0]    occ1, occ0;

    int compared   = 0;
    int mismatched = 0;

    beat_t q1[$];
    beat_t q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(oc0), .out_data(od0), .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready(input int n, input int cap);
        if (cap == 2) return n < 2;
        if (!rst) return out_ready;
        return (n == 0) || out_ready;
    endfunction

    task automatic check_all(input string tag);
        beat_t f;
        check({tag, ".ir1"}, ir1, m_ready(q1.size(), 2));
        check({tag, ".ov1"}, ov1, q1.size() > 0);
        check({tag, ".occ1"}, occ1, q1.size());
        if (q1.size() > 0) begin
            f = q1[0];
            check({tag, ".oc1"}, oc1, f[CW+DW-1:DW]);
            check({tag, ".od1"}, od1, f[DW-1:0]);
        end else begin
            check({tag, ".oc1"}, oc1, 0);
        end
        check({tag, ".ir0"}, ir0, m_ready(q0.size(), 1));
        check({tag, ".ov0"}, ov0, q0.size() > 0);
        check({tag, ".occ0"}, occ0, q0.size());
        if (q0.size() > 0) begin
            f = q0[0];
            check({tag, ".oc0"}, oc0, f[CW+DW-1:DW]);
            check({tag, ".od0"}, od0, f[DW-1:0]);
        end else begin
            check({tag, ".oc0"}, oc0, 0);
        end
        check({tag, ".nofull_accept"}, (occ1 == 2'd2) && ir1, 1'b0);
        check({tag, ".occ0_max"}, occ0 <= 2'd1, 1'b1);
    endtask

    // Applies one clock edge to both DUTs and to the reference queues.
    task automatic tick();
        logic  a1, a0, d1, d0;
        beat_t b;
        b  = {in_ctrl, in_data};
        a1 = in_valid && m_ready(q1.size(), 2) && !flush;
        a0 = in_valid && m_ready(q0.size(), 1) && !flush;
        d1 = (q1.size() > 0) && out_ready;
        d0 = (q0.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (d1) void'(q1.pop_front());
                if (a1) q1.push_back(b);
                if (d0) void'(q0.pop_front());
                if (a0) q0.push_back(b);
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);

        // Reset state
        #2;
        check("rst.od1", od1, 0);
        check("rst.od0", od0, 0);
        check_all("rst_or0");
        out_ready = 1'b1;
        #1;
        check_all("rst_or1");
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Streaming through the skid stage
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 12'h801, DW'(i));
            #1;
            check("stream.ir1", ir1, 1'b1);
            tick();
            check("stream.data", od1, DW'(i));
            check("stream.occ", occ1, 2'd1);
            check_all("stream");
        end
        drive(1'b0, '0, '0);
        tick();
        check_all("stream_end");

        // Stall fill, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 12'h123, DW'(8'hAA));
        tick();
        check("fill.occA", occ1, 2'd1);
        check_all("fillA");
        drive(1'b1, 12'h456, DW'(8'hBB));
        tick();
        check("fill.occB", occ1, 2'd2);
        check("fill.ir", ir1, 1'b0);
        check("fill.hold", od1, DW'(8'hAA));
        check_all("fillB");
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        #1;
        check("drain.first", od1, DW'(8'hAA));
        tick();
        check("drain.second", od1, DW'(8'hBB));
        check_all("drain1");
        tick();
        check("drain.empty", ov1, 1'b0);
        check_all("drain2");

        // Flush while full with a colliding input
        out_ready = 1'b0;
        drive(1'b1, 12'h801, DW'(1));
        tick();
        drive(1'b1, 12'h802, DW'(2));
        tick();
        check_all("pre_flush");
        drive(1'b1, 12'h803, DW'(8'hCC));
        flush = 1'b1;
        tick();
        check("flush.ov", ov1, 1'b0);
        check("flush.ctrl", oc1, 12'h000);
        check("flush.occ", occ1, 2'd0);
        check_all("flush");
        flush = 1'b0;
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        check_all("post_flush");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_all("flush_empty");

        // Asynchronous reset while stalled and full
        out_ready = 1'b0;
        drive(1'b1, 12'h811, DW'(3));
        tick();
        drive(1'b1, 12'h812, DW'(4));
        tick();
        check("pre_rst.occ", occ1, 2'd2);
        drive(1'b0, '0, '0);
        #1;
        rst = 1'b0;
        q1.delete();
        q0.delete();
        #1;
        check("arst.ov", ov1, 1'b0);
        check("arst.oc", oc1, 0);
        check("arst.od", od1, 0);
        check("arst.occ", occ1, 0);
        check_all("arst");
        tick();
        check_all("arst_hold");
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 12'h801, DW'(8'h55));
        tick();
        check("arst.fresh", od1, DW'(8'h55));
        check_all("arst_fresh");
        drive(1'b0, '0, '0);
        tick();

        // Pass-through ready on the single-entry stage
        out_ready = 1'b0;
        drive(1'b1, 12'h801, DW'(8'h0F));
        tick();
        drive(1'b0, '0, '0);
        check("pt.ov0", ov0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            out_ready = i[0];
            #1;
            check("pt.ir0", ir0, out_ready);
        end
        out_ready = 1'b0;
        tick();
        q1.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, 12'h801, DW'(8'h0E));
        tick();
        out_ready = 1'b1;
        drive(1'b1, 12'h801, DW'(8'h10));
        tick();
        check("pt.d10", od0, DW'(8'h10));
        check("pt.occ10", occ0, 2'd1);
        drive(1'b1, 12'h801, DW'(8'h11));
        tick();
        check("pt.d11", od0, DW'(8'h11));
        check("pt.occ11", occ0, 2'd1);
        check_all("pt");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom), 12'($urandom),
                  {$urandom, $urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            check_all("rand_pre");
            tick();
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
